// File: rtl/gates_input_conditioner.sv
// Input conditioning ahead of the gate block: synchronises and debounces the switches and the
// load button, and captures the vector operands vA/vB from the nibble bank on button presses.
module gates_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_raw,
   input  logic [3:0] nib_raw,
   input  logic       btn_raw,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic [3:0] vA,
   output logic [3:0] vB,
   output logic       next_sel,
   output logic       operands_valid
);

   localparam int NCH = 9;
   localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } load_state_t;

   logic [NCH-1:0] raw_all;
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;
   logic [NCH-1:0] stable;
   logic [CW-1:0]  cnt [NCH];

   logic [3:0]  nib_clean;
   logic        btn_stable;
   logic        btn_d;
   logic        press;

   load_state_t state;
   load_state_t state_next;
   logic [3:0]  va_next;
   logic [3:0]  vb_next;
   logic        valid_next;

   // Channel order: [8] button, [7:4] nibble bank, [3:0] scalar switches.
   assign raw_all = {btn_raw, nib_raw, sw_raw};

   // Any cycle where sync2 agrees with stable restarts the count, so only an unbroken
   // run of DEBOUNCE_CYCLES disagreeing cycles commits a new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw_all;
         sync2 <= sync1;
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign {A, B, C, D} = stable[3:0];
   assign nib_clean    = stable[7:4];
   assign btn_stable   = stable[8];
   assign press        = btn_stable & ~btn_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_d          <= 1'b0;
         state          <= EMPTY;
         vA             <= '0;
         vB             <= '0;
         operands_valid <= 1'b0;
      end else begin
         btn_d          <= btn_stable;
         state          <= state_next;
         vA             <= va_next;
         vB             <= vb_next;
         operands_valid <= valid_next;
      end
   end

   // Loads alternate vA, vB, vA, ... once the first pair is complete, EMPTY is never revisited.
   always_comb begin
      state_next = state;
      va_next    = vA;
      vb_next    = vB;
      valid_next = operands_valid;
      if (press) begin
         case (state)
            EMPTY: begin
               va_next    = nib_clean;
               state_next = HALF;
            end
            HALF: begin
               vb_next    = nib_clean;
               valid_next = 1'b1;
               state_next = FULL;
            end
            FULL: begin
               va_next    = nib_clean;
               valid_next = 1'b0;
               state_next = HALF;
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   assign next_sel = (state == HALF);

endmodule

// File: doc/gates_input_conditioner.md
# gates_input_conditioner

Input conditioning stage that sits directly upstream of the combinational gate block. It takes raw board switches and a push-button, synchronises and debounces them, and produces the clean scalar operands A, B, C, D. It also produces the 4-bit vector operands vA and vB, which a small load state machine captures from a nibble switch bank on successive button presses. All outputs are registered and glitch-free, so the downstream gate outputs change only on debounced, deliberate input changes.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a channel output changes; legal range 2..65535.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sw_raw  input  4  raw scalar switches; bit 3 maps to A, bit 2 to B, bit 1 to C, bit 0 to D.
- nib_raw  input  4  raw nibble switch bank; the source data for vA and vB.
- btn_raw  input  1  raw load push-button, active-high.
- A, B, C, D  output  1 each  debounced scalar operands.
- vA  output  4  captured vector operand A.
- vB  output  4  captured vector operand B.
- next_sel  output  1  target of the next load: 0 means vA, 1 means vB.
- operands_valid  output  1  high while vA and vB both hold values from the current load pair.

## Operation
- Nine independent channels: sw_raw[3:0], nib_raw[3:0] and btn_raw.
- Each channel has:
  - a 2-flop synchroniser (sync1, then sync2);
  - a stable register;
  - a counter of width clog2(DEBOUNCE_CYCLES).
- Per channel, on each edge:
  - if sync2 == stable: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - else: counter <= counter+1.
- Any single-cycle return to agreement restarts the count. Glitches shorter than DEBOUNCE_CYCLES cycles never reach the outputs.
- A, B, C, D are the stable registers of sw channels 3..0.
- nib_clean[3:0] is internal: the stable registers of the nibble channels.
- Press detection:
  - btn_d holds btn_stable delayed one cycle.
  - press = btn_stable & ~btn_d, which is exactly one cycle per debounced rising edge.
  - Holding the button loads only once; release generates nothing.
- Load FSM, 3 states, with transitions taken only on press:
  - EMPTY: vA <= nib_clean, go to HALF.
  - HALF: vB <= nib_clean, operands_valid <= 1, go to FULL.
  - FULL: vA <= nib_clean, operands_valid <= 0, go to HALF. vB retains its old value.
- next_sel is 1 in HALF and 0 in EMPTY and FULL. It is decoded from the state register, so it is glitch-free.
- Simultaneous nibble change and press: the load captures nib_clean as registered in the press-detect cycle. A nibble update committing on the same edge is not captured.
- No transitions occur without a press. vA and vB hold indefinitely.

## Timing
- Reset (rst_n low, asynchronous) values:
  - all sync, stable, btn_d and counter registers are 0;
  - A = B = C = D = 0;
  - vA = vB = 0;
  - state EMPTY, next_sel = 0, operands_valid = 0.
- Reset asserted mid-debounce or mid-sequence discards all progress immediately.
- After rst_n deassertion, raw inputs held at 1 appear on the outputs after the normal debounce latency.
- Switch latency: raw change sampled at edge k → sync2 at k+1 → stable updates at edge k+1+DEBOUNCE_CYCLES. With D=4, this is edge k+5.
- Load latency: btn_stable rises at edge e → vA, vB, state, next_sel and operands_valid update at edge e+1. From raw, this is edge k+2+DEBOUNCE_CYCLES.
- Minimum press spacing is 2·DEBOUNCE_CYCLES+2 cycles, because a release must also debounce before the next press.
- Counter wrap is impossible: the counter resets at DEBOUNCE_CYCLES-1.

## Test plan
- Reset: with DEBOUNCE_CYCLES=4, pulse rst_n low mid-run with all raw inputs at 1 → every output reads 0 on the same cycle. The outputs return to 1, and vA and vB stay 0, by edge 5 after release.
- Glitch rejection: sw_raw[3] high for 3 cycles, then low (D=4) → A stays 0 throughout. A 4-cycle bounce pattern 1,0,1,1,1,1 → A rises only after 4 consecutive high cycles at sync2.
- Clean latency: sw_raw = 4'b1010 sampled at edge k → A=1, B=0, C=1, D=0 first visible after edge k+5.
- Load sequence:
  - nib=5, press → vA=5, next_sel=1, valid=0.
  - nib=A, press → vB=A, next_sel=0, valid=1.
  - nib=3, press → vA=3, vB=A, next_sel=1, valid=0.
- Held button: btn_raw high for 200 cycles with nib=7 → exactly one load (vA=7). No further state change until release and re-press.
- Same-cycle edge: nibble debounce commits 9 on the press edge while nib_clean is 2 → vA=2 is captured. The next press captures 9.
